// File: rtl/clock_divider_mc.sv
// Multi-channel programmable clock divider with glitch-free bypass and phase-aligned restart.
// Optional macro CLK_DIV_ODD_DUTY50_EN adds a falling-edge flop giving 50% duty on odd ratios.
module clock_divider_mc #(
   parameter int NUM_CH  = 4,
   parameter int RATIO_W = 6
) (
   input  logic                      reference_clk,
   input  logic                      reset,
   input  logic [NUM_CH-1:0]         clk_divider_enable,
   input  logic [NUM_CH*RATIO_W-1:0] division_ratio,
   input  logic                      sync_restart,
   output logic [NUM_CH-1:0]         output_clk,
   output logic [NUM_CH-1:0]         div_active,
   output logic [NUM_CH-1:0]         ratio_applied
);

   typedef enum logic [1:0] {IDLE, RUN, STOPPING} ch_state_t;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      ch_state_t          state, state_n;
      logic [RATIO_W-1:0] counter, counter_n;
      logic [RATIO_W-1:0] shadow, shadow_n;
      logic [RATIO_W-1:0] ratio_in;
      logic               applied, applied_n;
      logic               bypass, wrap, reload, div_hi, gate;
      logic [RATIO_W:0]   half;

      assign ratio_in = division_ratio[i*RATIO_W +: RATIO_W];
      assign bypass   = (shadow[RATIO_W-1:1] == '0);
      assign wrap     = bypass || (counter == shadow - 1'b1);
      assign reload   = wrap && (ratio_in != shadow);

`ifdef CLK_DIV_ODD_DUTY50_EN
      assign half = {1'b0, shadow} >> 1;
`else
      assign half = ({1'b0, shadow} + 1'b1) >> 1;
`endif
      assign div_hi = (state != IDLE) && !bypass && ({1'b0, counter} < half);

      always_comb begin
         state_n   = state;
         counter_n = counter;
         shadow_n  = shadow;
         applied_n = 1'b0;
         case (state)
            IDLE: begin
               shadow_n  = ratio_in;
               counter_n = '0;
               if (clk_divider_enable[i]) state_n = RUN;
            end
            RUN: begin
               counter_n = wrap ? '0 : counter + 1'b1;
               if (!clk_divider_enable[i]) state_n = wrap ? IDLE : STOPPING;
               // Restart wins over ratio sampling on the same edge
               if (sync_restart) begin
                  counter_n = '0;
               end else if (reload && clk_divider_enable[i]) begin
                  shadow_n  = ratio_in;
                  applied_n = 1'b1;
               end
            end
            STOPPING: begin
               counter_n = wrap ? '0 : counter + 1'b1;
               if (clk_divider_enable[i]) begin
                  state_n = RUN;
                  if (reload) begin
                     shadow_n  = ratio_in;
                     applied_n = 1'b1;
                  end
               end else if (wrap) begin
                  state_n = IDLE;
               end
            end
            default: state_n = IDLE;
         endcase
      end

      always_ff @(posedge reference_clk or negedge reset) begin
         if (!reset) begin
            state   <= IDLE;
            counter <= '0;
            shadow  <= '0;
            applied <= 1'b0;
         end else begin
            state   <= state_n;
            counter <= counter_n;
            shadow  <= shadow_n;
            applied <= applied_n;
         end
      end

      // Bypass gate only changes while reference_clk is low, so no runt pulses
      always_ff @(negedge reference_clk or negedge reset) begin
         if (!reset) gate <= 1'b0;
         else        gate <= bypass && (state != IDLE) && clk_divider_enable[i];
      end

`ifdef CLK_DIV_ODD_DUTY50_EN
      logic ext_hi;

      // Half-cycle extension of the high phase for odd ratios
      always_ff @(negedge reference_clk or negedge reset) begin
         if (!reset) ext_hi <= 1'b0;
         else        ext_hi <= div_hi & shadow[0];
      end

      assign output_clk[i] = gate ? reference_clk : (div_hi | ext_hi);
`else
      assign output_clk[i] = gate ? reference_clk : div_hi;
`endif
      assign div_active[i]    = (state != IDLE);
      assign ratio_applied[i] = applied;
   end

endmodule
